// File: rtl/calc_pkg.sv
// Shared definitions for the calculator controller and the calculator datapath:
// state encodings, one-hot operation selects and the latched operand bundle.
package calc_pkg;

    localparam int unsigned DATA_W  = 8;
    localparam int unsigned RES_W   = 16;
    localparam int unsigned STATE_W = 3;
    localparam int unsigned SEL_W   = 3;

    localparam logic [STATE_W-1:0] ST_OFF  = 3'd0;
    localparam logic [STATE_W-1:0] ST_IDLE = 3'd1;
    localparam logic [STATE_W-1:0] ST_EXEC = 3'd2;
    localparam logic [STATE_W-1:0] ST_WAIT = 3'd3;
    localparam logic [STATE_W-1:0] ST_SHOW = 3'd4;

    localparam logic [SEL_W-1:0] SEL_NONE = 3'b000;
    localparam logic [SEL_W-1:0] SEL_MULT = 3'b001;
    localparam logic [SEL_W-1:0] SEL_SOMA = 3'b010;
    localparam logic [SEL_W-1:0] SEL_SUB  = 3'b100;

    typedef struct packed {
        logic              sinal_a;
        logic [DATA_W-1:0] a;
        logic              sinal_b;
        logic [DATA_W-1:0] b;
    } operands_t;

    // Fixed priority among operation buttons: mult > soma > sub.
    function automatic logic [SEL_W-1:0] op_select(input logic mult,
                                                   input logic soma,
                                                   input logic sub);
        logic [SEL_W-1:0] res;
        res = SEL_NONE;
        if (mult) begin
            res = SEL_MULT;
        end else if (soma) begin
            res = SEL_SOMA;
        end else if (sub) begin
            res = SEL_SUB;
        end
        return res;
    endfunction

endpackage

// File: rtl/botao_debounce.sv
// Button debouncer: level rises after DEBOUNCE_CYCLES consecutive high samples,
// drops on the first low sample; evento pulses once per rising level.
module botao_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic evento
);

    localparam int unsigned       CNT_W  = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]  THRESH = CNT_W'(DEBOUNCE_CYCLES - 1);

    // cnt holds the number of earlier consecutive high samples, saturating at THRESH
    logic [CNT_W-1:0] cnt;
    logic             rise_c;

    assign rise_c = raw && (cnt == THRESH) && !level;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            level  <= 1'b0;
            evento <= 1'b0;
        end else begin
            evento <= rise_c;
            if (!raw) begin
                cnt   <= '0;
                level <= 1'b0;
            end else if (cnt == THRESH) begin
                level <= 1'b1;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/calc_controller.sv
// Calculator front-panel controller: debounces the four buttons, sequences
// OFF/IDLE/EXEC/WAIT/SHOW, latches operands and registers the displayed result.
module calc_controller
    import calc_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              sinal_a,
    input  logic              sinal_b,
    input  logic              botao_1,
    input  logic              botao_2,
    input  logic              botao_3,
    input  logic              botao_4,
    input  logic [RES_W-1:0]  alu_saida,
    input  logic              alu_sinal,
    output logic [SEL_W-1:0]  sel,
    output logic [DATA_W-1:0] op_a,
    output logic [DATA_W-1:0] op_b,
    output logic              op_sinal_a,
    output logic              op_sinal_b,
    output logic [RES_W-1:0]  saida,
    output logic              sinal_saida,
    output logic              ligado,
    output logic              ocupado,
    output logic              resultado_valido
);

    logic       ev_mult;
    logic       ev_soma;
    logic       ev_sub;
    logic       ev_pwr;
    logic [3:0] unused_level;

    botao_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mult (
        .clk(clk), .rst(rst), .raw(botao_1), .level(unused_level[0]), .evento(ev_mult)
    );
    botao_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_soma (
        .clk(clk), .rst(rst), .raw(botao_2), .level(unused_level[1]), .evento(ev_soma)
    );
    botao_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sub (
        .clk(clk), .rst(rst), .raw(botao_3), .level(unused_level[2]), .evento(ev_sub)
    );
    botao_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_pwr (
        .clk(clk), .rst(rst), .raw(botao_4), .level(unused_level[3]), .evento(ev_pwr)
    );

    logic [STATE_W-1:0] state,    state_n;
    logic [SEL_W-1:0]   sel_q,    sel_n;
    operands_t          ops_q,    ops_n;
    logic [RES_W-1:0]   saida_q,  saida_n;
    logic               sinal_q,  sinal_n;
    logic               ligado_q, ligado_n;
    logic               ocup_q,   ocup_n;
    logic               valido_q, valido_n;
    logic [SEL_W-1:0]   op_sel_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_OFF;
            sel_q    <= SEL_NONE;
            ops_q    <= '0;
            saida_q  <= '0;
            sinal_q  <= 1'b0;
            ligado_q <= 1'b0;
            ocup_q   <= 1'b0;
            valido_q <= 1'b0;
        end else begin
            state    <= state_n;
            sel_q    <= sel_n;
            ops_q    <= ops_n;
            saida_q  <= saida_n;
            sinal_q  <= sinal_n;
            ligado_q <= ligado_n;
            ocup_q   <= ocup_n;
            valido_q <= valido_n;
        end
    end

    // Power event outranks every operation event in every powered state.
    always_comb begin
        state_n  = state;
        sel_n    = sel_q;
        ops_n    = ops_q;
        saida_n  = saida_q;
        sinal_n  = sinal_q;
        valido_n = 1'b0;
        op_sel_c = op_select(ev_mult, ev_soma, ev_sub);

        case (state)
            ST_OFF: begin
                if (ev_pwr) begin
                    state_n = ST_IDLE;
                end
            end
            ST_IDLE, ST_SHOW: begin
                if (ev_pwr) begin
                    state_n = ST_OFF;
                end else if (op_sel_c != SEL_NONE) begin
                    state_n       = ST_EXEC;
                    sel_n         = op_sel_c;
                    ops_n.sinal_a = sinal_a;
                    ops_n.a       = a;
                    ops_n.sinal_b = sinal_b;
                    ops_n.b       = b;
                end
            end
            ST_EXEC: begin
                state_n = ev_pwr ? ST_OFF : ST_WAIT;
            end
            ST_WAIT: begin
                if (ev_pwr) begin
                    state_n = ST_OFF;
                end else begin
                    state_n  = ST_SHOW;
                    saida_n  = alu_saida;
                    sinal_n  = alu_sinal && (alu_saida != '0);
                    valido_n = 1'b1;
                end
            end
            default: begin
                state_n = ST_OFF;
            end
        endcase

        // Entering or sitting in OFF always presents a cleared panel
        if (state_n == ST_OFF) begin
            sel_n   = SEL_NONE;
            ops_n   = '0;
            saida_n = '0;
            sinal_n = 1'b0;
        end

        ligado_n = (state_n != ST_OFF);
        ocup_n   = (state_n == ST_EXEC) || (state_n == ST_WAIT);
    end

    assign sel              = sel_q;
    assign op_a             = ops_q.a;
    assign op_b             = ops_q.b;
    assign op_sinal_a       = ops_q.sinal_a;
    assign op_sinal_b       = ops_q.sinal_b;
    assign saida            = saida_q;
    assign sinal_saida      = sinal_q;
    assign ligado           = ligado_q;
    assign ocupado          = ocup_q;
    assign resultado_valido = valido_q;

endmodule

// File: tb/tb_calc_controller.sv
// Bench for calc_controller: a behavioural calculator drives alu_*, a vector table,
// hand-written corner sequences and randomized transactions check the panel outputs.
module tb_calc_controller;
    import calc_pkg::*;

    localparam int unsigned DEB = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  a, b;
    logic        sinal_a, sinal_b;
    logic        botao_1, botao_2, botao_3, botao_4;
    logic [15:0] alu_saida;
    logic        alu_sinal;
    logic [2:0]  sel;
    logic [7:0]  op_a, op_b;
    logic        op_sinal_a, op_sinal_b;
    logic [15:0] saida;
    logic        sinal_saida, ligado, ocupado, resultado_valido;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    calc_controller #(.DEBOUNCE_CYCLES(DEB)) dut (
        .clk(clk), .rst(rst), .a(a), .b(b), .sinal_a(sinal_a), .sinal_b(sinal_b),
        .botao_1(botao_1), .botao_2(botao_2), .botao_3(botao_3), .botao_4(botao_4),
        .alu_saida(alu_saida), .alu_sinal(alu_sinal), .sel(sel),
        .op_a(op_a), .op_b(op_b), .op_sinal_a(op_sinal_a), .op_sinal_b(op_sinal_b),
        .saida(saida), .sinal_saida(sinal_saida), .ligado(ligado),
        .ocupado(ocupado), .resultado_valido(resultado_valido)
    );

    // Signed-magnitude calculator; mult keeps the xor sign even for a zero product.
    function automatic logic [16:0] calc_model(input logic [2:0] s, input logic [7:0] x,
                                               input logic [7:0] y, input logic sx,
                                               input logic sy);
        int vx, vy, r;
        logic [16:0] res;
        vx  = sx ? -int'(x) : int'(x);
        vy  = sy ? -int'(y) : int'(y);
        res = '0;
        r   = 0;
        case (s)
            SEL_MULT: res = {sx ^ sy, 16'(int'(x) * int'(y))};
            SEL_SOMA: begin r = vx + vy; res = {r < 0, 16'(r < 0 ? -r : r)}; end
            SEL_SUB:  begin r = vx - vy; res = {r < 0, 16'(r < 0 ? -r : r)}; end
            default:  res = '0;
        endcase
        return res;
    endfunction

    function automatic logic [16:0] shown(input logic [2:0] s, input logic [7:0] x,
                                          input logic [7:0] y, input logic sx,
                                          input logic sy);
        logic [16:0] r;
        r = calc_model(s, x, y, sx, sy);
        if (r[15:0] == 16'd0) r[16] = 1'b0;
        return r;
    endfunction

    function automatic logic [2:0] sel_of(input int op);
        case (op)
            1:       return 3'b001;
            2:       return 3'b010;
            3:       return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    assign {alu_sinal, alu_saida} = calc_model(sel, op_a, op_b, op_sinal_a, op_sinal_b);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_btn(input int idx, input logic v);
        case (idx)
            1: botao_1 = v;
            2: botao_2 = v;
            3: botao_3 = v;
            default: botao_4 = v;
        endcase
    endtask

    task automatic power_on();
        botao_4 = 1'b1;
        repeat (DEB) tick();
        check("pwr_before", 32'(ligado), 32'd0);
        tick();
        check("pwr_ligado", 32'(ligado), 32'd1);
        check("pwr_sel", 32'(sel), 32'd0);
        tick();
        botao_4 = 1'b0;
        tick();
    endtask

    typedef struct {
        int          op;
        logic [7:0]  x, y;
        logic        sx, sy;
        logic [2:0]  sel;
        logic [15:0] res;
        logic        sgn;
    } vec_t;

    vec_t vecs[8];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses, busy, lat;
        logic got, busy_seen;
        logic [15:0] held;
        logic [16:0] exp;

        vecs[0] = '{2, 8'd12,  8'd5,   1'b0, 1'b0, 3'b010, 16'd17,    1'b0};
        vecs[1] = '{1, 8'd7,   8'd6,   1'b0, 1'b0, 3'b001, 16'd42,    1'b0};
        vecs[2] = '{3, 8'd3,   8'd3,   1'b0, 1'b0, 3'b100, 16'd0,     1'b0};
        vecs[3] = '{2, 8'd12,  8'd5,   1'b1, 1'b0, 3'b010, 16'd7,     1'b1};
        vecs[4] = '{3, 8'd5,   8'd200, 1'b0, 1'b1, 3'b100, 16'd205,   1'b0};
        vecs[5] = '{1, 8'd0,   8'd9,   1'b1, 1'b0, 3'b001, 16'd0,     1'b0};
        vecs[6] = '{1, 8'd255, 8'd255, 1'b1, 1'b0, 3'b001, 16'd65025, 1'b1};
        vecs[7] = '{3, 8'd10,  8'd30,  1'b0, 1'b0, 3'b100, 16'd20,    1'b1};

        rst = 1'b1; a = '0; b = '0; sinal_a = 0; sinal_b = 0;
        botao_1 = 0; botao_2 = 0; botao_3 = 0; botao_4 = 0;
        tick(); tick();
        check("rst_ligado", 32'(ligado), 32'd0);
        check("rst_ocupado", 32'(ocupado), 32'd0);
        check("rst_valid", 32'(resultado_valido), 32'd0);
        check("rst_saida", 32'(saida), 32'd0);
        check("rst_sel", 32'(sel), 32'd0);
        rst = 1'b0;
        tick();

        // operation events while OFF are ignored
        botao_2 = 1'b1;
        repeat (DEB + 2) tick();
        check("off_ignore_ocupado", 32'(ocupado), 32'd0);
        check("off_ignore_ligado", 32'(ligado), 32'd0);
        botao_2 = 1'b0;
        tick();

        power_on();

        foreach (vecs[i]) begin
            a = vecs[i].x; b = vecs[i].y; sinal_a = vecs[i].sx; sinal_b = vecs[i].sy;
            set_btn(vecs[i].op, 1'b1);
            repeat (DEB) tick();
            check("vec_pre_ocupado", 32'(ocupado), 32'd0);
            tick();
            check("vec_exec_ocupado", 32'(ocupado), 32'd1);
            check("vec_exec_sel", 32'(sel), 32'(vecs[i].sel));
            a = 8'd1; b = ~vecs[i].y; sinal_a = ~vecs[i].sx; sinal_b = ~vecs[i].sy;
            tick();
            set_btn(vecs[i].op, 1'b0);
            check("vec_wait_ocupado", 32'(ocupado), 32'd1);
            check("vec_wait_valid", 32'(resultado_valido), 32'd0);
            tick();
            check("vec_show_valid", 32'(resultado_valido), 32'd1);
            check("vec_show_saida", 32'(saida), 32'(vecs[i].res));
            check("vec_show_sinal", 32'(sinal_saida), 32'(vecs[i].sgn));
            check("vec_show_ocupado", 32'(ocupado), 32'd0);
            check("vec_show_sel", 32'(sel), 32'(vecs[i].sel));
            tick();
            check("vec_after_valid", 32'(resultado_valido), 32'd0);
            check("vec_hold_saida", 32'(saida), 32'(vecs[i].res));
        end

        // glitch shorter than the debounce window
        botao_1 = 1'b1;
        repeat (DEB - 1) tick();
        botao_1 = 1'b0;
        busy_seen = 1'b0;
        repeat (8) begin tick(); if (ocupado) busy_seen = 1'b1; end
        check("glitch_busy", 32'(busy_seen), 32'd0);
        check("glitch_saida", 32'(saida), 32'd20);
        check("glitch_sel", 32'(sel), 32'b100);

        // botao_2 event lands in WAIT and is dropped
        a = 8'd2; b = 8'd3; sinal_a = 0; sinal_b = 0;
        botao_1 = 1'b1;
        pulses = 0; busy = 0;
        for (int k = 1; k <= 16; k++) begin
            tick();
            if (k == 2) botao_2 = 1'b1;
            if (k == 6) botao_1 = 1'b0;
            if (k == 8) botao_2 = 1'b0;
            if (resultado_valido) pulses++;
            if (ocupado) busy++;
        end
        check("drop_pulses", 32'(pulses), 32'd1);
        check("drop_busy_cycles", 32'(busy), 32'd2);
        check("drop_saida", 32'(saida), 32'd6);
        check("drop_sel", 32'(sel), 32'b001);

        // mult and power events together in SHOW
        botao_1 = 1'b1; botao_4 = 1'b1;
        repeat (DEB + 1) tick();
        check("both_ligado", 32'(ligado), 32'd0);
        check("both_saida", 32'(saida), 32'd0);
        check("both_sel", 32'(sel), 32'd0);
        busy_seen = ocupado;
        repeat (3) begin tick(); if (ocupado) busy_seen = 1'b1; end
        check("both_no_exec", 32'(busy_seen), 32'd0);
        botao_1 = 1'b0; botao_4 = 1'b0;
        tick(); tick();
        power_on();

        // power event in WAIT
        a = 8'd4; b = 8'd4;
        botao_1 = 1'b1;
        tick(); tick();
        botao_4 = 1'b1;
        repeat (4) tick();
        check("pwr_wait_busy", 32'(ocupado), 32'd1);
        tick();
        check("pwr_wait_ligado", 32'(ligado), 32'd0);
        check("pwr_wait_valid", 32'(resultado_valido), 32'd0);
        check("pwr_wait_saida", 32'(saida), 32'd0);
        botao_1 = 1'b0; botao_4 = 1'b0;
        pulses = 0;
        repeat (6) begin tick(); if (resultado_valido) pulses++; end
        check("pwr_wait_no_pulse", 32'(pulses), 32'd0);
        power_on();

        // reset during EXEC
        a = 8'd9; b = 8'd1;
        botao_3 = 1'b1;
        repeat (DEB + 1) tick();
        check("rst_exec_busy", 32'(ocupado), 32'd1);
        rst = 1'b1; botao_3 = 1'b0;
        tick();
        check("rst_exec_ligado", 32'(ligado), 32'd0);
        check("rst_exec_ocupado", 32'(ocupado), 32'd0);
        check("rst_exec_sel", 32'(sel), 32'd0);
        check("rst_exec_op_a", 32'(op_a), 32'd0);
        check("rst_exec_saida", 32'(saida), 32'd0);

        // power button held through reset release
        botao_4 = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        repeat (DEB) tick();
        check("held_rst_before", 32'(ligado), 32'd0);
        tick();
        check("held_rst_ligado", 32'(ligado), 32'd1);
        botao_4 = 1'b0;
        tick();

        // randomized transactions against the calculator model
        for (int t = 0; t < 40; t++) begin
            int op, hold;
            op = int'($urandom_range(1, 3));
            hold = int'($urandom_range(DEB, DEB + 5));
            a = 8'($urandom); b = 8'($urandom);
            sinal_a = 1'($urandom); sinal_b = 1'($urandom);
            if ($urandom_range(0, 4) == 0) a = 8'd0;
            exp = shown(sel_of(op), a, b, sinal_a, sinal_b);
            set_btn(op, 1'b1);
            got = 1'b0; pulses = 0; lat = 0;
            for (int k = 1; k <= 20; k++) begin
                tick();
                if (k == hold) set_btn(op, 1'b0);
                if (k == DEB + 1) begin
                    a = 8'($urandom); b = 8'($urandom);
                    sinal_a = 1'($urandom); sinal_b = 1'($urandom);
                end
                if (resultado_valido) begin
                    pulses++;
                    if (!got) begin
                        got = 1'b1;
                        lat = k;
                        check("rnd_saida", 32'(saida), 32'(exp[15:0]));
                        check("rnd_sinal", 32'(sinal_saida), 32'(exp[16]));
                    end
                end
                if (got && k >= hold) break;
            end
            set_btn(op, 1'b0);
            check("rnd_got_result", 32'(got), 32'd1);
            check("rnd_latency", 32'(lat), 32'(DEB + 3));
            tick();
            if (resultado_valido) pulses++;
            check("rnd_single_pulse", 32'(pulses), 32'd1);

            if ($urandom_range(0, 2) == 0) begin
                held = saida;
                set_btn(int'($urandom_range(1, 3)), 1'b1);
                repeat (int'($urandom_range(1, DEB - 1))) tick();
                botao_1 = 0; botao_2 = 0; botao_3 = 0;
                busy_seen = 1'b0;
                repeat (DEB + 3) begin tick(); if (ocupado) busy_seen = 1'b1; end
                check("rnd_glitch_busy", 32'(busy_seen), 32'd0);
                check("rnd_glitch_saida", 32'(saida), 32'(held));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
